// File: rtl/uart_tx_frame.sv
// uart_tx_frame: single-channel UART transmitter producing one framed character
// per accepted payload: start bit, DATA_W data bits (LSB first), optional
// parity bit, one or two stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
// Optional feature macro: UART_TX_PARITY_INJECT_EN adds the par_inject input,
// which inverts the parity of the accepted frame for error-injection testing.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              par_en,
  input  logic              even_odd,
  input  logic              stop2,
`ifdef UART_TX_PARITY_INJECT_EN
  input  logic              par_inject,
`endif
  output logic              tx_out,
  output logic              tx_busy,
  output logic              parity_bit
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              even_odd_q, even_odd_d;
  logic              stop2_q, stop2_d;
  logic              parity_q, parity_d;
  logic              tx_out_q, tx_out_d;
  logic              bit_end;
  logic              accept_parity;
  logic              frame_parity;

`ifdef UART_TX_PARITY_INJECT_EN
  logic              inject_q, inject_d;
  // Parity computed from the incoming payload (loaded into parity_bit at accept)
  // and from the latched copy (driven onto the line in the parity slot).
  assign accept_parity = (^tx_data_in) ^ even_odd ^ par_inject;
  assign frame_parity  = (^data_q) ^ even_odd_q ^ inject_q;
`else
  assign accept_parity = (^tx_data_in) ^ even_odd;
  assign frame_parity  = (^data_q) ^ even_odd_q;
`endif

  // The block is only ready while idle; busy is simply the complement.
  assign tx_ready   = (state_q == IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_out     = tx_out_q;
  assign parity_bit = parity_q;

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state, next-bit and latch logic; tx_out_d is the value for the next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    even_odd_d = even_odd_q;
    stop2_d    = stop2_q;
    parity_d   = parity_q;
    tx_out_d   = tx_out_q;
`ifdef UART_TX_PARITY_INJECT_EN
    inject_d   = inject_q;
`endif

    // Bit-period counter runs in every non-idle state and wraps at each bit.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        cnt_d    = '0;
        idx_d    = '0;
        if (tx_valid) begin
          data_d     = tx_data_in;
          par_en_d   = par_en;
          even_odd_d = even_odd;
          stop2_d    = stop2;
`ifdef UART_TX_PARITY_INJECT_EN
          inject_d   = par_inject;
`endif
          parity_d   = accept_parity;
          tx_out_d   = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d    = '0;
          tx_out_d = data_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              tx_out_d = frame_parity;
              state_d  = PARITY;
            end else begin
              tx_out_d = 1'b1;
              state_d  = STOP;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            tx_out_d = data_q[idx_d];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          idx_d    = '0;
          tx_out_d = 1'b1;
          state_d  = STOP;
        end
      end
      STOP: begin
        tx_out_d = 1'b1;
        if (bit_end) begin
          if (stop2_q && (idx_q == '0)) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        tx_out_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      even_odd_q <= 1'b0;
      stop2_q    <= 1'b0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
`ifdef UART_TX_PARITY_INJECT_EN
      inject_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      even_odd_q <= even_odd_d;
      stop2_q    <= stop2_d;
      parity_q   <= parity_d;
      tx_out_q   <= tx_out_d;
`ifdef UART_TX_PARITY_INJECT_EN
      inject_q   <= inject_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with DATA_W=8, CLKS_PER_BIT=4.
// Frames are captured on falling edges and decoded into one bit per bit period
// (bit 0 of the decoded vector is the start bit).
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       even_odd = 1'b0;
  logic       stop2 = 1'b0;
`ifdef UART_TX_PARITY_INJECT_EN
  logic       par_inject = 1'b0;
`endif
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       parity_bit;

  int         checks = 0;
  int         errors = 0;
  logic       samp [0:255];
  int         cap_len;
  logic [15:0] cap_bits;
  int         cap_bad_hold;
  int         cap_ready_bad;

  uart_tx_frame #(
    .DATA_W       (8),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data_in (tx_data_in),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .par_en     (par_en),
    .even_odd   (even_odd),
    .stop2      (stop2),
`ifdef UART_TX_PARITY_INJECT_EN
    .par_inject (par_inject),
`endif
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .parity_bit (parity_bit)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a payload at a falling edge and return at the first frame cycle.
  task automatic send(input logic [7:0] d, input logic pe, input logic eo, input logic s2);
    tx_data_in = d;
    par_en     = pe;
    even_odd   = eo;
    stop2      = s2;
    tx_valid   = 1'b1;
    @(negedge clk);
  endtask

  // Sample tx_out every cycle while busy; drop tx_valid at sample drop_at.
  task automatic capture(input int drop_at);
    cap_len       = 0;
    cap_ready_bad = 0;
    while (tx_busy === 1'b1 && cap_len < 200) begin
      if (cap_len == drop_at) tx_valid = 1'b0;
      samp[cap_len] = tx_out;
      if (tx_ready !== 1'b0) cap_ready_bad++;
      cap_len++;
      @(negedge clk);
    end
    cap_bits     = '0;
    cap_bad_hold = 0;
    for (int b = 0; b < 16 && b * 4 < cap_len; b++) begin
      cap_bits[b] = samp[b * 4];
      for (int j = 1; j < 4; j++) begin
        if (b * 4 + j < cap_len && samp[b * 4 + j] !== samp[b * 4]) cap_bad_hold++;
      end
    end
  endtask

  // Compare a captured frame and the idle cycle that follows it.
  task automatic frame_checks(input string name, input logic [15:0] exp_bits,
                              input int exp_len, input logic exp_par);
    check({name, ".len"}, cap_len, exp_len);
    check({name, ".bits"}, {16'h0, cap_bits}, {16'h0, exp_bits});
    check({name, ".hold"}, cap_bad_hold, 0);
    check({name, ".ready_low"}, cap_ready_bad, 0);
    check({name, ".idle_tx_out"}, {31'h0, tx_out}, 32'h1);
    check({name, ".idle_ready"}, {31'h0, tx_ready}, 32'h1);
    check({name, ".parity_bit"}, {31'h0, parity_bit}, {31'h0, exp_par});
    $display("frame %s bits=0x%04h len=%0d parity_bit=%b", name, cap_bits, cap_len, parity_bit);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst.tx_out", {31'h0, tx_out}, 32'h1);
    check("rst.tx_ready", {31'h0, tx_ready}, 32'h1);
    check("rst.tx_busy", {31'h0, tx_busy}, 32'h0);
    check("rst.parity_bit", {31'h0, parity_bit}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 8'h11, even parity, one stop: 0 | 1000 1000 | 0 | 1
    send(8'h11, 1'b1, 1'b0, 1'b0);
    capture(0);
    frame_checks("h11_even", 16'h0422, 44, 1'b0);

    // 8'h1a odd parity -> parity 0
    send(8'h1a, 1'b1, 1'b1, 1'b0);
    capture(0);
    frame_checks("h1a_odd", 16'h0434, 44, 1'b0);

    // 8'h1a even parity -> parity 1 in the slot
    send(8'h1a, 1'b1, 1'b0, 1'b0);
    capture(0);
    frame_checks("h1a_even", 16'h0634, 44, 1'b1);

    // 8'hA5, no parity, two stops; payload changes and tx_valid stays high mid-frame
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    tx_data_in = 8'h00;
    capture(20);
    frame_checks("hA5_stop2", 16'h074A, 44, 1'b0);
    repeat (3) @(negedge clk);
    check("hA5.no_queued_frame", {31'h0, tx_ready}, 32'h1);
    check("hA5.no_queued_line", {31'h0, tx_out}, 32'h1);

    // Reset during data bit 3 (payload 0 so the line is low there)
    send(8'h00, 1'b1, 1'b1, 1'b0);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("midrst.pre_tx_out", {31'h0, tx_out}, 32'h0);
    check("midrst.pre_parity", {31'h0, parity_bit}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst.tx_out", {31'h0, tx_out}, 32'h1);
    check("midrst.tx_ready", {31'h0, tx_ready}, 32'h1);
    check("midrst.tx_busy", {31'h0, tx_busy}, 32'h0);
    check("midrst.parity_bit", {31'h0, parity_bit}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst.tx_out", {31'h0, tx_out}, 32'h1);
    check("postrst.tx_ready", {31'h0, tx_ready}, 32'h1);
    $display("frame midrst reset applied during data bit 3");

    // Complete frame after reset: 8'h3C, no parity, one stop
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    capture(0);
    frame_checks("h3C_postrst", 16'h0278, 40, 1'b0);

    // tx_valid held continuously: 8'h55 then 8'hAA
    send(8'h55, 1'b0, 1'b0, 1'b0);
    tx_data_in = 8'hAA;
    capture(-1);
    frame_checks("h55_cont", 16'h02AA, 40, 1'b0);
    @(negedge clk);
    capture(0);
    frame_checks("hAA_cont", 16'h0354, 40, 1'b0);

`ifdef UART_TX_PARITY_INJECT_EN
    // Injected parity error on 8'h11 even
    par_inject = 1'b1;
    send(8'h11, 1'b1, 1'b0, 1'b0);
    par_inject = 1'b0;
    capture(0);
    frame_checks("h11_inject", 16'h0622, 44, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
